// File: rtl/prio_arb_seg_pkg.sv
// Shared constants for the priority arbiter with 7-segment readout:
// arbitration mode encodings and active-low segment glyphs (bit 7 = DP).
package prio_arb_seg_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // All segments and the decimal point off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low glyphs, bit order {dp,g,f,e,d,c,b,a}; index 15 first so
    // that SEG_HEX[n] yields the glyph for hex digit n.
    localparam logic [15:0][7:0] SEG_HEX = {
        8'h8E,  // F
        8'h86,  // E
        8'hA1,  // d
        8'hC6,  // C
        8'h83,  // b
        8'h88,  // A
        8'h90,  // 9
        8'h80,  // 8
        8'hF8,  // 7
        8'h82,  // 6
        8'h92,  // 5
        8'h99,  // 4
        8'hB0,  // 3
        8'hA4,  // 2
        8'hF9,  // 1
        8'hC0   // 0
    };

endpackage

// File: rtl/prio_arb_seg_hex7seg.sv
// Hex nibble to active-low 7-segment decoder with a blanking input.
module hex7seg
    import prio_arb_seg_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       blank,
    output logic [7:0] seg
);

    // Pick the glyph for the nibble, or all-off when blanked.
    always_comb begin
        // NOTE: assigning a default first on every path keeps this purely combinational (no latch).
        seg = SEG_BLANK;
        if (!blank) begin
            seg = SEG_HEX[nib];
        end
    end

endmodule

// File: rtl/prio_arb_seg.sv
// Priority arbiter with fixed (MSB-first) and downward round-robin modes,
// a valid/ready output register, a change pulse and two hex digit displays.
module prio_arb_seg
    import prio_arb_seg_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] idx,
    output logic         chg,
    output logic [7:0]   seg0,
    output logic [7:0]   seg1
);

    localparam logic [W-1:0] PTR_MAX = W'(N - 1);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] idx_q, idx_d;
    logic         chg_q, chg_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic         accept;
    logic         load;
    logic [W-1:0] ptr_eff;
    logic [W-1:0] fix_idx;
    logic [W-1:0] rr_idx;
    logic         rr_found;
    logic [W-1:0] cand_idx;
    logic [7:0]   idx_ext;

    assign accept = out_valid_q && out_ready;
    assign load   = !out_valid_q || out_ready;

    // Search start for round-robin: a grant being accepted this edge moves the
    // pointer just below it, and the new candidate must already see that move
    // so consecutive accepted grants step down instead of repeating.
    always_comb begin
        ptr_eff = ptr_q;
        if ((mode == MODE_RR) && accept) begin
            ptr_eff = (idx_q == '0) ? PTR_MAX : idx_q - W'(1);
        end
    end

    // Fixed priority: the last set bit seen in an ascending scan is the highest.
    always_comb begin
        fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                fix_idx = W'(i);
            end
        end
    end

    // Round-robin: first set bit going down from ptr_eff, wrapping N-1 after 0.
    always_comb begin : rr_search
        int pos;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr_eff) - k;
            if (pos < 0) begin
                pos = pos + N;
            end
            if (!rr_found && req[pos[W-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = pos[W-1:0];
            end
        end
    end

    assign cand_idx = (mode == MODE_RR) ? rr_idx : fix_idx;

    // Next grant, change pulse and pointer; the grant only moves on a load.
    always_comb begin
        out_valid_d = out_valid_q;
        idx_d       = idx_q;
        if (load) begin
            if (en && (|req)) begin
                out_valid_d = 1'b1;
                idx_d       = cand_idx;
            end else begin
                out_valid_d = 1'b0;
                idx_d       = '0;
            end
        end
        chg_d = load && ((out_valid_d != out_valid_q) || (idx_d != idx_q));
        ptr_d = (mode == MODE_FIXED) ? PTR_MAX : ptr_eff;
    end

    // State registers; reset clears the grant and parks the pointer at the top.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values.
        if (!rst) begin
            out_valid_q <= 1'b0;
            idx_q       <= '0;
            chg_q       <= 1'b0;
            ptr_q       <= PTR_MAX;
        end else begin
            out_valid_q <= out_valid_d;
            idx_q       <= idx_d;
            chg_q       <= chg_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign idx       = idx_q;
    assign chg       = chg_q;

    // Zero-extend the index to two nibbles so unused upper bits display as 0.
    always_comb begin
        idx_ext = 8'(idx_q);
    end

    hex7seg u_hex_lo (
        .nib   (idx_ext[3:0]),
        .blank (!out_valid_q),
        .seg   (seg0)
    );

    hex7seg u_hex_hi (
        .nib   (idx_ext[7:4]),
        .blank (!out_valid_q || (W <= 4)),
        .seg   (seg1)
    );

endmodule

// File: doc/prio_arb_seg.md
PRIO_ARB_SEG -- requirements
Module: prio_arb_seg

Interface
REQ-001 SHALL have parameter N, default 8, number of request lines (legal range 2..256).
REQ-002 SHALL have parameter W, default $clog2(N), width of the index output (derived; not overridden).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  N  request vector; bit i set = line i requesting.
REQ-006 SHALL have port en  input  1  encoder enable; low = no grant produced.
REQ-007 SHALL have port mode  input  1  0 = fixed priority (MSB highest), 1 = round-robin.
REQ-008 SHALL have port out_valid  output  1  registered index is a valid grant.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the current grant.
REQ-010 SHALL have port idx  output  W  registered granted index.
REQ-011 SHALL have port chg  output  1  one-cycle pulse: loaded result differs from the previous one.
REQ-012 SHALL have port seg0  output  8  active-low 7-segment + DP for idx[3:0].
REQ-013 SHALL have port seg1  output  8  active-low 7-segment + DP for idx[7:4].

Function
REQ-014 Fixed mode candidate SHALL be the highest-numbered set bit of req.
REQ-015 Round-robin candidate SHALL be the first set bit found by searching ptr, ptr-1, ..., 0, N-1, ..., ptr+1.
REQ-016 A load SHALL occur on a clock edge when out_valid is 0 or out_ready is 1.
REQ-017 On a load with en=1 and req non-zero, the block SHALL set out_valid to 1 and idx to the candidate.
REQ-018 On a load with en=0 or req all-zero, the block SHALL set out_valid to 0 and idx to 0.
REQ-019 Latency SHALL be exactly one clock from req/en/mode sampled to idx/out_valid.
REQ-020 While out_valid=1 and out_ready=0, idx and out_valid SHALL hold stable, whatever req/en/mode do.
REQ-021 ptr SHALL be W bits wide.
REQ-022 On out_valid && out_ready with mode=1, ptr SHALL become (idx==0) ? N-1 : idx-1.
REQ-023 While mode=0, ptr SHALL be forced to N-1 each cycle, so round-robin entry starts from fixed-priority order.
REQ-024 A mode change SHALL affect only the next load; a held grant is unaffected.
REQ-025 chg SHALL be 1 for exactly one cycle after a load in which out_valid or idx differs from its pre-load value; otherwise 0.
REQ-026 seg0/seg1 SHALL be combinational hex decodes of the registered idx nibbles (0-F glyphs); DP bit [7] SHALL always be 1 (off).
REQ-027 When out_valid=0, seg0 and seg1 SHALL be blank (all 1).
REQ-028 When W<=4, seg1 SHALL be blank (all 1).
REQ-029 Bits of idx above W SHALL be treated as 0 by the display.
REQ-030 With a single requester held asserted in mode=1, the grant SHALL repeat that index on every accepted cycle.

Reset
REQ-031 While rst=0, the block SHALL hold out_valid=0, idx=0, chg=0, ptr=N-1, seg0/seg1 = 8'hFF, asynchronously.
REQ-032 A reset asserted mid-hold SHALL drop the grant immediately; no grant survives reset.
REQ-033 The first load SHALL happen on the first rising edge after rst deasserts.

Structure
REQ-034 The shared package SHALL hold the glyph constants (SEG_BLANK = 8'hFF and the 16 hex patterns) and the mode encodings (MODE_FIXED=0, MODE_RR=1).
REQ-035 The design SHALL contain one sub-module, hex7seg (4-bit in, 8-bit active-low out, blank input), instantiated twice.
REQ-036 Candidate search, ptr, output register and chg logic SHALL live in prio_arb_seg.

Verification (N=8)
REQ-037 Reset release, en=1, mode=0, req=8'b0010_0110, out_ready=1 -> after 1 clk: out_valid=1, idx=5, chg=1, seg0=hex 5 glyph, seg1=8'hFF.
REQ-038 mode=1, req=8'hFF, out_ready=1 held for 9 clks -> idx sequence 7,6,5,4,3,2,1,0,7; chg=1 every cycle.
REQ-039 Grant idx=3 valid, out_ready=0, req changed to 8'h80 and en=0 for 4 clks -> idx stays 3, out_valid stays 1, chg=0; out_ready=1 -> next clk out_valid=0, idx=0, chg=1, segments blank.
REQ-040 mode=1, last accepted idx=0, req=8'b1000_0001 -> next grant 7 (wrap); then mode=0, req=8'b0000_0001 -> grant 0 with ptr=7.
REQ-041 rst pulled low while out_valid=1 and out_ready=0 -> out_valid=0, idx=0, seg0=seg1=8'hFF with no clock edge.
REQ-042 N=16, mode=0, req=16'h0000 then 16'h8001 -> out_valid=0, then idx=15; seg0=hex F glyph, seg1=8'hFF.
